// File: rtl/mult_unit.sv
// Multi-cycle unsigned WIDTH x WIDTH shift-add multiplier with architectural HI/LO.
// Optional MULT_EARLY_EXIT_EN: leave RUN as soon as the remaining multiplier bits are all zero.
module mult_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       ALUctrl,
   input  logic             valid,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output logic             busy,
   output logic             done,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [5:0] MULTU = 6'h13;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               r_state, w_state_nxt;
   logic [2*WIDTH-1:0]   r_acc, r_mcand, w_acc_nxt;
   logic [WIDTH-1:0]     r_mplier, w_mplier_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic                 w_req, w_accept, w_last;

   assign w_req        = valid & (ALUctrl == MULTU);
   assign w_acc_nxt    = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_mplier_nxt = r_mplier >> 1;

`ifdef MULT_EARLY_EXIT_EN
   assign w_last = (r_cnt == CNT_W'(WIDTH-1)) | (w_mplier_nxt == '0);
`else
   assign w_last = (r_cnt == CNT_W'(WIDTH-1));
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: if (w_req) begin
            w_state_nxt = RUN;
            w_accept    = 1'b1;
         end
         RUN:  if (w_last) w_state_nxt = DONE;
         DONE: begin
            w_state_nxt = w_req ? RUN : IDLE;
            w_accept    = w_req;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign busy  = (r_state == RUN);
   assign done  = (r_state == DONE);
   // Combinational so the issuing instruction is held from its very first EX cycle.
   assign stall = busy | (w_req & (r_state != RUN));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         hi       <= '0;
         lo       <= '0;
      end else if (w_accept) begin
         r_acc    <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, opA};
         r_mplier <= opB;
         r_cnt    <= '0;
      end else if (r_state == RUN) begin
         r_acc    <= w_acc_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= w_mplier_nxt;
         r_cnt    <= r_cnt + CNT_W'(1);
         // HI/LO take the final sum including this edge's partial product.
         if (w_last) {hi, lo} <= w_acc_nxt;
      end
   end

endmodule

// File: tb/tb_mult_unit.sv
// Directed self-checking bench for mult_unit; latency expectations follow MULT_EARLY_EXIT_EN.
module tb_mult_unit;

   logic        clk, rst, valid, busy, done, stall;
   logic [5:0]  ALUctrl;
   logic [31:0] opA, opB, hi, lo;
   int          nchk, nerr, edges, busyc, dcount;

`ifdef MULT_EARLY_EXIT_EN
   localparam int LAT_3X5 = 3;
   localparam int LAT_B0  = 1;
   localparam int LAT_6X7 = 3;
`else
   localparam int LAT_3X5 = 32;
   localparam int LAT_B0  = 32;
   localparam int LAT_6X7 = 32;
`endif

   mult_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .ALUctrl(ALUctrl), .valid(valid), .opA(opA), .opB(opB),
      .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request cycle, confirm the same-cycle stall, then drop it after the accept edge.
   task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b);
      opA = a; opB = b; ALUctrl = 6'h13; valid = 1'b1;
      #1;
      check({tag, "_stall_req"}, stall, 1'b1);
      tick();
      valid = 1'b0; ALUctrl = 6'h00;
      check({tag, "_busy_rise"}, busy, 1'b1);
   endtask

   task automatic wait_done(input string tag, output int e, output int bc);
      e = 0; bc = 0;
      for (int i = 0; i < 100; i++) begin
         if (busy) bc++;
         tick();
         e++;
         if (done === 1'b1) break;
      end
      check({tag, "_done_seen"}, done, 1'b1);
   endtask

   initial begin
      nchk = 0; nerr = 0;
      rst = 1'b1; valid = 1'b0; ALUctrl = 6'h00; opA = '0; opB = '0;
      repeat (2) tick();
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_stall", stall, 1'b0);
      check("rst_hilo", {hi, lo}, 64'h0);
      rst = 1'b0;
      tick();

      // 3 * 5
      issue("m3x5", 32'd3, 32'd5);
      wait_done("m3x5", edges, busyc);
      check("m3x5_latency", edges, LAT_3X5);
      check("m3x5_busycyc", busyc, LAT_3X5);
      check("m3x5_busy_at_done", busy, 1'b0);
      check("m3x5_hilo", {hi, lo}, 64'd15);
      tick();
      check("m3x5_done_pulse", done, 1'b0);
      check("m3x5_hold", {hi, lo}, 64'd15);

      // all-ones operands
      issue("mff", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("mff", edges, busyc);
      check("mff_latency", edges, 32);
      check("mff_hi", hi, 32'hFFFF_FFFE);
      check("mff_lo", lo, 32'h0000_0001);
      tick();

      // non-multiply codes and invalid requests are ignored
      opA = 32'd9; opB = 32'd9; valid = 1'b1;
      ALUctrl = 6'h02; #1; check("ign02_stall", stall, 1'b0); tick(); check("ign02_busy", busy, 1'b0);
      ALUctrl = 6'h12; #1; check("ign12_stall", stall, 1'b0); tick(); check("ign12_busy", busy, 1'b0);
      ALUctrl = 6'h32; #1; check("ign32_stall", stall, 1'b0); tick(); check("ign32_busy", busy, 1'b0);
      ALUctrl = 6'h13; valid = 1'b0; #1; check("inv_stall", stall, 1'b0); tick(); check("inv_busy", busy, 1'b0);
      check("ign_hilo_held", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});
      ALUctrl = 6'h00;

      // request during RUN is ignored
      issue("mid", 32'd7, 32'h8000_0001);
      repeat (10) tick();
      opA = 32'd100; opB = 32'd100; ALUctrl = 6'h13; valid = 1'b1;
      #1; check("mid_stall", stall, 1'b1);
      tick();
      valid = 1'b0; ALUctrl = 6'h00;
      wait_done("mid", edges, busyc);
      check("mid_latency", edges + 11, 32);
      check("mid_hilo", {hi, lo}, {32'd3, 32'h8000_0007});
      tick();

      // back-to-back accept on the done cycle
      issue("b2b1", 32'd5, 32'h8000_0003);
      wait_done("b2b1", edges, busyc);
      check("b2b1_hilo", {hi, lo}, {32'd2, 32'h8000_000F});
      opA = 32'd6; opB = 32'd7; ALUctrl = 6'h13; valid = 1'b1;
      #1; check("b2b_stall_on_done", stall, 1'b1);
      tick();
      valid = 1'b0; ALUctrl = 6'h00;
      check("b2b_busy_next", busy, 1'b1);
      check("b2b_done_low", done, 1'b0);
      check("b2b_hilo_held", {hi, lo}, {32'd2, 32'h8000_000F});
      wait_done("b2b2", edges, busyc);
      check("b2b2_latency", edges, LAT_6X7);
      check("b2b2_hilo", {hi, lo}, 64'd42);
      tick();

      // zero multiplier
      issue("mb0", 32'd123, 32'd0);
      wait_done("mb0", edges, busyc);
      check("mb0_latency", edges, LAT_B0);
      check("mb0_hilo", {hi, lo}, 64'd0);
      tick();

      // restore nonzero HI/LO, then async reset mid-run
      issue("pre", 32'd3, 32'd5);
      wait_done("pre", edges, busyc);
      check("pre_hilo", {hi, lo}, 64'd15);
      tick();
      issue("rstmid", 32'd10, 32'h8000_0000);
      repeat (15) tick();
      check("rstmid_busy_before", busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("rstmid_busy", busy, 1'b0);
      check("rstmid_done", done, 1'b0);
      check("rstmid_hilo", {hi, lo}, 64'h0);
      #1 rst = 1'b0;
      dcount = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done === 1'b1) dcount++;
      end
      check("rstmid_no_done", dcount, 0);

      // recovery after reset
      issue("post", 32'd3, 32'd5);
      wait_done("post", edges, busyc);
      check("post_latency", edges, LAT_3X5);
      check("post_hilo", {hi, lo}, 64'd15);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Multi-cycle unsigned 32x32 multiplier with architectural HI/LO registers.
- Sits directly downstream of the ALU controller in the EX stage.
- Consumes the 6-bit ALU control code; a request is accepted only when the code is 6'h13 (multiply unsigned).
- Stalls the pipeline while a multiply is in flight. HI/LO feed the mfhi/mflo datapath; the ALU treats those instructions as nop (ALU control code 6'h0).

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, asynchronous, active-high
ALUctrl  input  6  ALU control code from the ALU controller
valid  input  1  EX stage holds a live instruction this cycle
opA  input  WIDTH  multiplicand (rs)
opB  input  WIDTH  multiplier (rt)
busy  output  1  multiply in progress
done  output  1  one-cycle pulse: HI/LO just updated
stall  output  1  pipeline hold request
hi  output  WIDTH  HI register (upper product half)
lo  output  WIDTH  LO register (lower product half)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, stall=0, hi=0, lo=0, counter=0, internal accumulator and operand registers=0.
- req = valid & (ALUctrl == 6'h13). All other codes are ignored, including shifts, add, and 6'h32.
- States:
  - IDLE: req -> RUN.
  - RUN: each edge processes one multiplier bit. After the last bit -> DONE.
  - DONE: one cycle. req -> RUN (back-to-back accept); otherwise -> IDLE.
- Accept edge:
  - Latch mcand = {WIDTH'b0, opA} (2*WIDTH bits) and mplier = opB.
  - Clear acc (2*WIDTH bits) and counter.
- Each RUN edge:
  - If mplier[0], acc += mcand (modulo 2^(2*WIDTH)).
  - mcand <<= 1, mplier >>= 1, counter += 1.
  - On the edge where counter reaches WIDTH-1 -> DONE, with {hi, lo} loaded from the final acc value, including this edge's addition.
- Latency: done is high for exactly one cycle, beginning WIDTH edges after the accepting edge (32 for the default). hi/lo are valid in that same cycle and held until the next completion.
- busy = (state == RUN).
- stall = busy | (req & state != RUN), combinational, so the issuing instruction is held in EX from its first cycle.
- A req arriving while in RUN is ignored; no queueing. The pipeline is stalled, so the same instruction re-presents.
- done and req in the same cycle: accept the new multiply. HI/LO keep the just-written result until the new one completes.
- hi/lo never change except on entry to DONE or on reset.
- rst mid-operation: abort immediately. hi/lo clear to 0 and no done pulse occurs.
- Operands are sampled only at the accept edge; opA/opB changes during RUN have no effect.

Optional Feature:
MULT_EARLY_EXIT_EN
- Defined: RUN also exits when the shifted mplier becomes zero after an edge's processing, or when the counter limit is reached, whichever comes first. The minimum is 1 RUN edge; the result is identical to the full run.
- Undefined: always exactly WIDTH RUN edges, fixed latency.

Test Plan:
- Reset, then opA=3, opB=5, ALUctrl=6'h13, valid=1 for one cycle -> stall=1 in the request cycle. busy=1 for 32 cycles. done pulses 32 edges after accept, with hi=0, lo=15.
- opA=opB=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001 at done.
- ALUctrl=6'h02, 6'h12 and 6'h32 with valid=1 -> busy=0, stall=0, hi/lo unchanged. ALUctrl=6'h13 with valid=0 -> no accept.
- Second req at RUN cycle 10 with different operands -> ignored, and the first result is delivered. A req held through the done cycle -> accepted back-to-back, and busy rises the next cycle.
- Assert rst asynchronously at RUN cycle 15 -> busy, done, hi and lo go to 0 without waiting for an edge. No done pulse follows.
- With MULT_EARLY_EXIT_EN: 3*5 -> done 3 edges after accept, lo=15. opB=0 -> done after 1 edge, hi=lo=0. Without the macro: both take 32 edges.
